// File: rtl/data_mem_responder_if.sv
// Core-to-responder data-memory bus: strobes, byte address and store data towards the responder,
// and combinational load data back to the core.
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] RWAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] MemData;

  modport master (output MemRead, MemWrite, RWAddress, WriteData, input MemData);
  modport slave  (input MemRead, MemWrite, RWAddress, WriteData, output MemData);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO bank holding GPIO out, synchronised GPIO in,
// sticky clear-on-read rising-edge flags and a free-running cycle counter. Bad accesses set a sticky err.
module data_mem_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] DATA_BASE  = 32'h1001_0000,
  parameter logic [DATA_WIDTH-1:0] IO_BASE    = 32'h1001_0400,
  parameter int                    GPIO_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  input  logic [GPIO_W-1:0]     gpio_in,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic                  err
);
  localparam int                    IDX_W     = $clog2(DEPTH);
  localparam logic [DATA_WIDTH-1:0] RAM_BYTES = DATA_WIDTH'(DEPTH * 4);
  localparam logic [DATA_WIDTH-1:0] IO_BYTES  = DATA_WIDTH'(32'd16);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE   = DATA_WIDTH'(1'b1);

  logic [DATA_WIDTH-1:0] ram_r [DEPTH];
  logic [GPIO_W-1:0]     sync1_r, sync2_r, prev_r, edge_r, gpio_out_r;
  logic [DATA_WIDTH-1:0] cnt_r;
  logic                  err_r;

  logic [DATA_WIDTH-1:0] ram_off_s, io_off_s, rd_data_s;
  logic                  ram_hit_s, io_hit_s, valid_s, rd_ok_s, wr_ok_s;
  logic [IDX_W-1:0]      ram_idx_s;
  logic [1:0]            io_sel_s;
  logic [GPIO_W-1:0]     rise_s;

  // Address decode; offsets wrap below the base so one unsigned compare bounds each window.
  always_comb begin
    ram_off_s = bus.RWAddress - DATA_BASE;
    io_off_s  = bus.RWAddress - IO_BASE;
    ram_hit_s = (ram_off_s < RAM_BYTES);
    io_hit_s  = (io_off_s < IO_BYTES);
    valid_s   = (bus.RWAddress[1:0] == 2'b00) && (ram_hit_s || io_hit_s) &&
                !(bus.MemRead && bus.MemWrite);
    rd_ok_s   = bus.MemRead && valid_s;
    wr_ok_s   = bus.MemWrite && valid_s;
    ram_idx_s = ram_off_s[IDX_W+1:2];
    io_sel_s  = io_off_s[3:2];
    rise_s    = sync2_r & ~prev_r;
  end

  // Load data mux: RAM read is asynchronous, so a same-cycle store is not yet visible.
  always_comb begin
    rd_data_s = '0;
    if (rd_ok_s && ram_hit_s) begin
      rd_data_s = ram_r[ram_idx_s];
    end else if (rd_ok_s) begin
      case (io_sel_s)
        2'd0:    rd_data_s = DATA_WIDTH'(gpio_out_r);
        2'd1:    rd_data_s = DATA_WIDTH'(sync2_r);
        2'd2:    rd_data_s = DATA_WIDTH'(edge_r);
        2'd3:    rd_data_s = cnt_r;
        default: rd_data_s = '0;
      endcase
    end else begin
      rd_data_s = '0;
    end
  end

  assign bus.MemData = rd_data_s;

  // RAM array keeps its contents across reset; stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wr_ok_s && ram_hit_s) begin
      ram_r[ram_idx_s] <= bus.WriteData;
    end
  end

  // MMIO registers, GPIO synchroniser, edge flags, cycle counter and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      prev_r     <= '0;
      edge_r     <= '0;
      gpio_out_r <= '0;
      cnt_r      <= '0;
      err_r      <= 1'b0;
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      // A flag rising in the clearing cycle must survive the clear.
      if (rd_ok_s && io_hit_s && (io_sel_s == 2'd2)) begin
        edge_r <= rise_s;
      end else begin
        edge_r <= edge_r | rise_s;
      end
      if (wr_ok_s && io_hit_s && (io_sel_s == 2'd0)) begin
        gpio_out_r <= bus.WriteData[GPIO_W-1:0];
      end else begin
        gpio_out_r <= gpio_out_r;
      end
      if (wr_ok_s && io_hit_s && (io_sel_s == 2'd3)) begin
        cnt_r <= bus.WriteData;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if ((bus.MemRead || bus.MemWrite) && !valid_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign gpio_out = gpio_out_r;
  assign err      = err_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a randomized phase, all checked
// against a cycle-indexed reference model built from address-map and timing rules.
module tb_data_mem_responder;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam int          GW    = 8;
  localparam logic [31:0] DB    = 32'h1001_0000;
  localparam logic [31:0] IB    = 32'h1001_0400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [GW-1:0] gpio_in = '0;
  logic [GW-1:0] gpio_out;
  logic          err;

  data_mem_responder_if #(.DATA_WIDTH(DW)) bus ();

  data_mem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DATA_BASE(DB), .IO_BASE(IB), .GPIO_W(GW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .gpio_in(gpio_in), .gpio_out(gpio_out), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: RAM image, register values, and gpio_in history indexed by cycle since reset.
  logic [31:0]   ram_m [DEPTH];
  bit            known_m [DEPTH];
  logic [GW-1:0] gout_m, flags_m;
  bit            err_m;
  logic [31:0]   cnt_base_m;
  int            cnt_from_m;
  logic [GW-1:0] hist_m [$];
  logic [31:0]   obs_v, exp_v;
  bit            chk_v;

  function automatic logic [GW-1:0] gin_seen(int k);
    if (k < 2 || (k - 2) >= hist_m.size()) return '0;
    return hist_m[k-2];
  endfunction

  function automatic bit in_ram(logic [31:0] a);
    return (a >= DB) && (a < DB + 32'(DEPTH * 4));
  endfunction

  function automatic bit in_io(logic [31:0] a);
    return (a >= IB) && (a < IB + 32'd16);
  endfunction

  function automatic bit acc_ok(bit rd, bit wr, logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (in_ram(a) || in_io(a)) && !(rd && wr);
  endfunction

  task automatic model_reset();
    gout_m = '0; flags_m = '0; err_m = 1'b0;
    cnt_base_m = '0; cnt_from_m = 0;
    hist_m.delete();
  endtask

  // One bus cycle starting just after a rising edge; leaves obs_v/exp_v/chk_v for the caller.
  task automatic cycle(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [GW-1:0] gin);
    bit v; int idx; int n; logic [31:0] off; logic [GW-1:0] rise;
    bus.MemRead = rd; bus.MemWrite = wr; bus.RWAddress = addr; bus.WriteData = wdata; gpio_in = gin;
    n = hist_m.size(); v = acc_ok(rd, wr, addr); off = addr - IB;
    idx = in_ram(addr) ? int'((addr - DB) >> 2) : 0;
    exp_v = '0; chk_v = 1'b1;
    if (rd && v) begin
      if (in_ram(addr)) begin exp_v = ram_m[idx]; chk_v = known_m[idx]; end
      else if (off == 32'd0) exp_v = 32'(gout_m);
      else if (off == 32'd4) exp_v = 32'(gin_seen(n));
      else if (off == 32'd8) exp_v = 32'(flags_m);
      else exp_v = cnt_base_m + 32'(n - cnt_from_m);
    end
    @(negedge clk);
    obs_v = bus.MemData;
    @(posedge clk);
    rise = gin_seen(n) & ~gin_seen(n - 1);
    if (rd && v && in_io(addr) && off == 32'd8) flags_m = rise;
    else flags_m = flags_m | rise;
    if (wr && v) begin
      if (in_ram(addr)) begin ram_m[idx] = wdata; known_m[idx] = 1'b1; end
      else if (off == 32'd0) gout_m = wdata[GW-1:0];
      else if (off == 32'd12) begin cnt_base_m = wdata; cnt_from_m = n + 1; end
    end
    if ((rd || wr) && !v) err_m = 1'b1;
    hist_m.push_back(gin);
    #1;
  endtask

  task automatic test_reset();
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.RWAddress = '0; bus.WriteData = '0;
    rst = 1'b0; #2;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out: got %h expected 00", gpio_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    @(posedge clk); #1; rst = 1'b1; model_reset();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL idle_memdata: got %h expected 0", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd12, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'd1) begin errors++; $display("FAIL reset_cnt: got %h expected 1", obs_v); end
  endtask

  task automatic test_ram();
    int idx; logic [31:0] d;
    cycle(1'b0, 1'b1, DB + 32'd8, 32'hDEAD_BEEF, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL ram_write_cycle: got %h expected 0", obs_v); end
    cycle(1'b1, 1'b0, DB + 32'd8, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_readback: got %h expected deadbeef", obs_v); end
    for (int i = 0; i < 24; i++) begin
      idx = int'($urandom_range(0, DEPTH - 1)); d = $urandom;
      cycle(1'b0, 1'b1, DB + 32'(idx * 4), d, 8'h00);
      cycle(1'b1, 1'b0, DB + 32'(idx * 4), 32'h0, 8'h00);
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL ram_rand[%0d]: got %h expected %h", idx, obs_v, exp_v); end
      idx = int'($urandom_range(0, DEPTH - 1));
      cycle(1'b1, 1'b0, DB + 32'(idx * 4), 32'h0, 8'h00);
      if (chk_v) begin
        checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL ram_other[%0d]: got %h expected %h", idx, obs_v, exp_v); end
      end
    end
  endtask

  task automatic test_gpio();
    cycle(1'b0, 1'b1, IB, 32'hFFFF_FFA5, 8'h00);
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_out: got %h expected a5", gpio_out); end
    cycle(1'b1, 1'b0, IB, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0000_00A5) begin errors++; $display("FAIL gpio_out_read: got %h expected 000000a5", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd4, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL gpio_in_0edge: got %h expected 0", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd4, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL gpio_in_1edge: got %h expected 0", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd4, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h3) begin errors++; $display("FAIL gpio_in_2edge: got %h expected 3", obs_v); end
  endtask

  task automatic test_edge();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    cycle(1'b1, 1'b0, IB + 32'd8, 32'h0, 8'h00);
    checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL edge_prelude: got %h expected %h", obs_v, exp_v); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 8'h01);
    cycle(1'b1, 1'b0, IB + 32'd8, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h01) begin errors++; $display("FAIL edge_bit0: got %h expected 01", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd8, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h00) begin errors++; $display("FAIL edge_cleared: got %h expected 00", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd8, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h00) begin errors++; $display("FAIL edge_clear_cycle: got %h expected 00", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd8, 32'h0, 8'h03);
    checks++; if (obs_v !== 32'h02) begin errors++; $display("FAIL edge_survive: got %h expected 02", obs_v); end
  endtask

  task automatic test_counter();
    cycle(1'b0, 1'b1, IB + 32'd12, 32'hFFFF_FFFF, 8'h00);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    cycle(1'b1, 1'b0, IB + 32'd12, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL cnt_wrap: got %h expected 0", obs_v); end
    cycle(1'b0, 1'b1, IB + 32'd12, 32'h1234_5678, 8'h00);
    cycle(1'b1, 1'b0, IB + 32'd12, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h1234_5678) begin errors++; $display("FAIL cnt_load: got %h expected 12345678", obs_v); end
    cycle(1'b1, 1'b0, IB + 32'd12, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h1234_5679) begin errors++; $display("FAIL cnt_load_inc: got %h expected 12345679", obs_v); end
  endtask

  task automatic test_errors();
    cycle(1'b0, 1'b1, DB, 32'h1111_2222, 8'h00);
    cycle(1'b0, 1'b1, DB + 32'd252, 32'h7777_8888, 8'h00);
    cycle(1'b1, 1'b0, DB + 32'd252, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h7777_8888) begin errors++; $display("FAIL ram_last_word: got %h expected 77778888", obs_v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b expected 0", err); end
    cycle(1'b1, 1'b0, DB + 32'd2, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL misaligned_data: got %h expected 0", obs_v); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b expected 1", err); end
    cycle(1'b1, 1'b0, 32'h2000_0000, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL unmapped_data: got %h expected 0", obs_v); end
    cycle(1'b1, 1'b1, DB, 32'h0000_0BAD, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL both_strobes_data: got %h expected 0", obs_v); end
    cycle(1'b1, 1'b0, DB + 32'd256, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL past_ram_data: got %h expected 0", obs_v); end
    cycle(1'b0, 1'b1, IB + 32'd16, 32'h0000_00FF, 8'h00);
    cycle(1'b0, 1'b1, IB + 32'd2, 32'h0000_00FF, 8'h00);
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL bad_write_gpio: got %h expected a5", gpio_out); end
    cycle(1'b1, 1'b0, DB, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h1111_2222) begin errors++; $display("FAIL both_strobes_ram: got %h expected 11112222", obs_v); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_random();
    logic [31:0] a; bit rd, wr; int r;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = DB + 32'($urandom_range(0, DEPTH - 1) * 4);
        2:       a = IB + 32'($urandom_range(0, 3) * 4);
        3:       a = DB + 32'($urandom_range(0, 300));
        4:       a = IB + 32'($urandom_range(0, 31));
        default: a = $urandom;
      endcase
      r = int'($urandom_range(0, 9));
      rd = (r < 5) || (r == 9); wr = (r >= 5 && r < 8) || (r == 9);
      cycle(rd, wr, a, $urandom, GW'($urandom_range(0, 255)));
      if (chk_v) begin
        checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rand_memdata[%0d] @%h: got %h expected %h", i, a, obs_v, exp_v); end
      end
      checks++; if (gpio_out !== gout_m || err !== err_m) begin
        errors++; $display("FAIL rand_regs[%0d]: got gpio %h err %b expected gpio %h err %b", i, gpio_out, err, gout_m, err_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, DB + 32'd16, 32'hCAFE_F00D, 8'h00);
    cycle(1'b0, 1'b1, IB, 32'h0000_003C, 8'h00);
    cycle(1'b1, 1'b0, DB + 32'd1, 32'h0, 8'h00);
    checks++; if (gpio_out !== 8'h3C || err !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got gpio %h err %b expected 3c 1", gpio_out, err);
    end
    bus.MemRead = 1'b0; bus.MemWrite = 1'b1; bus.RWAddress = IB; bus.WriteData = 32'h0000_0099;
    #2; rst = 1'b0; #1;
    checks++; if (gpio_out !== 8'h00 || err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got gpio %h err %b expected 00 0", gpio_out, err);
    end
    bus.MemWrite = 1'b0;
    @(posedge clk); #1; rst = 1'b1; model_reset();
    cycle(1'b1, 1'b0, DB + 32'd16, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_kept: got %h expected cafef00d", obs_v); end
    cycle(1'b1, 1'b0, IB, 32'h0, 8'h00);
    checks++; if (obs_v !== 32'h0) begin errors++; $display("FAIL gpio_after_reset: got %h expected 0", obs_v); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_edge();
    test_counter();
    test_errors();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
